// File: rtl/arith_enc_pkg.sv
// Shared types for the arithmetic-encoder output path: FIFO entry layout,
// serializer states and the tail-entry builder used on flush.
package arith_enc_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [1:0]        nbytes;
        logic              last;
    } stream_entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } ser_state_e;

    // Keep only the top b bits of the tail; b=0 still emits a single zero byte.
    function automatic stream_entry_t make_tail_entry(input logic [WORD_W-1:0] fdata,
                                                      input logic [4:0]        fbits);
        stream_entry_t       e;
        logic [4:0]          b;
        logic [2*WORD_W-1:0] mask_wide;
        b         = (fbits > 5'd16) ? 5'd16 : fbits;
        mask_wide = {{WORD_W{1'b1}}, {WORD_W{1'b0}}} >> b;
        e.data    = fdata & mask_wide[WORD_W-1:0];
        e.nbytes  = (b <= 5'd8) ? 2'd1 : 2'd2;
        e.last    = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/word_fifo_2w.sv
// DEPTH-entry FIFO with two write ports (port 0 wins on space) and one read
// port; writes that do not fit are dropped and flagged for one cycle.
module word_fifo_2w
    import arith_enc_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr0_en_i,
    input  stream_entry_t       wr0_entry_i,
    input  logic                wr1_en_i,
    input  stream_entry_t       wr1_entry_i,
    input  logic                rd_en_i,
    output stream_entry_t       rd_entry_o,
    output logic                empty_o,
    output logic [LVL_W-1:0]    level_o,
    output logic                drop_o
);

    stream_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [LVL_W-1:0]   free;
    logic               pop, acc0, acc1;

    // A same-edge pop frees one slot for this cycle's pushes.
    always_comb begin
        pop      = rd_en_i && (level_q != '0);
        free     = LVL_W'(DEPTH) - level_q + LVL_W'(pop);
        acc0     = wr0_en_i && (free != '0);
        acc1     = wr1_en_i && (free > LVL_W'(acc0));
        drop_o   = (wr0_en_i && !acc0) || (wr1_en_i && !acc1);
        wr_ptr_d = wr_ptr_q + PTR_W'(acc0) + PTR_W'(acc1);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(acc0) + LVL_W'(acc1) - LVL_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (acc0) mem_q[wr_ptr_q] <= wr0_entry_i;
        if (acc1) mem_q[wr_ptr_q + PTR_W'(acc0)] <= wr1_entry_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rd_entry_o = mem_q[rd_ptr_q];
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;

endmodule

// File: rtl/packed_word_streamer.sv
// Buffers packed 16-bit words (plus a flush tail) and streams them MSB-first
// as bytes over valid/ready, marking the final byte of the stream.
module packed_word_streamer
    import arith_enc_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BYTE_COUNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_W-1:0]         word_in,
    input  logic                      word_valid,
    input  logic                      flush_valid,
    input  logic [WORD_W-1:0]         flush_data,
    input  logic [4:0]                flush_bits,
    output logic [BYTE_W-1:0]         m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic [BYTE_COUNT_W-1:0]   byte_count
);

    ser_state_e                 state_q, state_d;
    stream_entry_t              cur_q, cur_d;
    stream_entry_t              word_entry, tail_entry, head;
    logic                       overflow_q;
    logic [BYTE_COUNT_W-1:0]    byte_count_q;
    logic                       fifo_empty, fifo_drop;
    logic                       hs, load, pop;

    assign word_entry = '{data: word_in, nbytes: 2'd2, last: 1'b0};
    assign tail_entry = make_tail_entry(flush_data, flush_bits);

    word_fifo_2w #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr0_en_i    (word_valid),
        .wr0_entry_i (word_entry),
        .wr1_en_i    (flush_valid),
        .wr1_entry_i (tail_entry),
        .rd_en_i     (pop),
        .rd_entry_o  (head),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level),
        .drop_o      (fifo_drop)
    );

    // load marks a cycle where the serializer is free to take the next entry;
    // popping in that same cycle avoids a bubble between entries.
    always_comb begin
        hs      = m_valid && m_ready;
        load    = 1'b0;
        state_d = state_q;
        case (state_q)
            S_IDLE: load = 1'b1;
            S_HI: begin
                if (hs) begin
                    if (cur_q.nbytes == 2'd2) state_d = S_LO;
                    else                      load    = 1'b1;
                end
            end
            S_LO:    if (hs) load = 1'b1;
            default: state_d = S_IDLE;
        endcase
        pop = load && !fifo_empty;
        if (load) state_d = pop ? S_HI : S_IDLE;
        cur_d = pop ? head : cur_q;
    end

    always_comb begin
        m_data = '0;
        m_last = 1'b0;
        case (state_q)
            S_HI: begin
                m_data = cur_q.data[WORD_W-1:BYTE_W];
                m_last = cur_q.last && (cur_q.nbytes == 2'd1);
            end
            S_LO: begin
                m_data = cur_q.data[BYTE_W-1:0];
                m_last = cur_q.last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            overflow_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            overflow_q   <= overflow_q | fifo_drop;
            byte_count_q <= byte_count_q + BYTE_COUNT_W'(hs);
        end
    end

    assign m_valid    = (state_q != S_IDLE);
    assign overflow   = overflow_q;
    assign byte_count = byte_count_q;

endmodule
